platform_gen2: RTL and testbench
================================

Name: platform_gen2

Overview:
- Parametrised successor to the single-row platform renderer.
- Holds the paddle's left-edge position, moved by left/right on enable ticks with a configurable step and edge clamping.
- On a draw request, rasterises a WIDTH x HEIGHT rectangle to the VGA plotter, one pixel per clock.
- Optionally erases the previously drawn rectangle first, so the frame loop does not need a full-screen clear.

Parameters:
- WIDTH, 32, paddle width in pixels (1..X_MAX+1)
- HEIGHT, 2, paddle height in rows (1..8)
- SPEED, 2, pixels moved per enable tick (1..15)
- X_MAX, 159, rightmost legal screen column
- X_INIT, 64, left-edge position after reset
- Y_POS, 110, top row of paddle
- COLOUR, 3'b100, paddle draw colour

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- left  in  1  move-left request, sampled with enable
- right  in  1  move-right request, sampled with enable
- enable  in  1  movement tick (one cycle per frame)
- draw  in  1  start-render request, level or pulse
- x  out  10  pixel column to plot
- y  out  10  pixel row to plot
- colour  out  3  pixel colour (COLOUR, or 3'b000 when erasing)
- writeEn  out  1  pixel write strobe
- busy  out  1  high from accepted draw until done
- done  out  1  one-cycle pulse after the final pixel
- d_x  out  10  current paddle left edge, for collision logic

Behaviour:
- Reset (async, resetn=0):
  - d_x=X_INIT; state IDLE; writeEn=0, busy=0, done=0.
  - x=X_INIT, y=Y_POS, colour=COLOUR.
  - drawn_valid=0. Applies mid-operation: the scan aborts and writeEn drops immediately.
- Movement, every clock in every state:
  - enable & left & !right: d_x <= (d_x >= SPEED) ? d_x-SPEED : 0.
  - enable & right & !left: d_x <= min(d_x+SPEED, X_MAX-WIDTH+1).
  - left & right together, or enable=0: d_x is unchanged.
  - Arithmetic is 11-bit internally; no wrap-around is possible.
- FSM states: IDLE, ERASE, DRAW, DONE.
  - IDLE: on a clock edge with draw=1:
    - snapshot sx <= d_x; clear row/col counters; busy <= 1.
    - next state is ERASE if erase is enabled, drawn_valid=1 and last_x != d_x; otherwise DRAW.
  - ERASE: scans the rectangle at last_x with colour 3'b000, writeEn=1. After the last pixel, clear the counters and go to DRAW.
  - DRAW: scans the rectangle at sx with COLOUR, writeEn=1. After the last pixel: last_x <= sx, drawn_valid <= 1, go to DONE.
  - DONE: writeEn=0, done=1 for exactly one cycle, busy <= 0, then IDLE.
- Scan order is row-major: row 0..HEIGHT-1, col 0..WIDTH-1 within each row.
  - x = base + col; y = Y_POS + row; one pixel per cycle with no gaps.
- Latency: first writeEn is in the cycle after draw is accepted. A full render is WIDTH*HEIGHT write cycles, or 2*WIDTH*HEIGHT with erase, plus 1 DONE cycle.
- draw while busy is ignored. draw held high restarts only after DONE returns to IDLE.
- Movement during busy updates d_x, but the render uses snapshot sx; the rectangle is never torn.
- Outside ERASE/DRAW: x=sx, y=Y_POS, colour=COLOUR, writeEn=0.

Optional Feature:
- Macro PLAT_ERASE_EN.
- Defined: ERASE state built, last_x/drawn_valid tracked, behaviour as above.
- Undefined: ERASE state and last_x are not synthesised. IDLE always goes to DRAW, and every render is exactly WIDTH*HEIGHT writes.

Test Plan:
- Reset, then a 1-cycle draw pulse -> 64 writes; x=64..95 on y=110, then y=111; colour=100; one done pulse at write count 64+1; d_x=64.
- PLAT_ERASE_EN: enable+right for 3 ticks (d_x=70), then draw -> 64 writes colour 000 at x=64..95, then 64 writes colour 100 at x=70..101; busy high for 129 cycles.
- Clamp: enable+right for 40 ticks -> d_x=128. Then enable+left for 70 ticks -> d_x=0, with no wrap to 1023.
- left&right both high with enable, and left with enable=0 -> d_x unchanged over 10 cycles.
- During DRAW: pulse draw again and move left 1 tick -> second draw ignored; pixels stay at the snapshot x; d_x reflects the move.
- Assert resetn=0 at pixel 20 of DRAW -> writeEn=0 and busy=0 asynchronously, d_x=64. The next draw does no erase, 64 writes.

Source files
------------

// File: rtl/platform_gen2.sv
// Paddle renderer: tracks a clamped left-edge position and rasterises a WIDTH x HEIGHT
// rectangle to a VGA plotter. Define PLAT_ERASE_EN to erase the previous rectangle first.
module platform_gen2 #(
    parameter int         WIDTH  = 32,
    parameter int         HEIGHT = 2,
    parameter int         SPEED  = 2,
    parameter int         X_MAX  = 159,
    parameter int         X_INIT = 64,
    parameter int         Y_POS  = 110,
    parameter logic [2:0] COLOUR = 3'b100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       left,
    input  logic       right,
    input  logic       enable,
    input  logic       draw,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [2:0] colour,
    output logic       writeEn,
    output logic       busy,
    output logic       done,
    output logic [9:0] d_x
);

    localparam int COL_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int RIGHT_LIM = X_MAX - WIDTH + 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

`ifdef PLAT_ERASE_EN
    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
`endif

    state_t           state;
    logic [9:0]       sx;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
`ifdef PLAT_ERASE_EN
    logic [9:0]       last_x;
    logic             drawn_valid;
`endif

    // Movement datapath is one bit wider than the position so the clamp never sees a wrap.
    logic [10:0] dx_wide;
    logic [10:0] dx_inc;
    assign dx_wide = {1'b0, d_x};
    assign dx_inc  = dx_wide + 11'(SPEED);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_x <= 10'(X_INIT);
        end else if (enable && left && !right) begin
            d_x <= (dx_wide >= 11'(SPEED)) ? 10'(dx_wide - 11'(SPEED)) : '0;
        end else if (enable && right && !left) begin
            d_x <= (dx_inc > 11'(RIGHT_LIM)) ? 10'(RIGHT_LIM) : dx_inc[9:0];
        end
    end

    logic       last_pixel;
    logic       col_wrap;
    logic [9:0] scan_base;
    assign col_wrap   = (col == COL_LAST);
    assign last_pixel = col_wrap && (row == ROW_LAST);
`ifdef PLAT_ERASE_EN
    assign scan_base  = (state == ERASE) ? last_x : sx;
`else
    assign scan_base  = sx;
`endif

    // Outputs are registered: each edge loads the pixel that will be visible next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            sx      <= 10'(X_INIT);
            col     <= '0;
            row     <= '0;
            x       <= 10'(X_INIT);
            y       <= 10'(Y_POS);
            colour  <= COLOUR;
            writeEn <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef PLAT_ERASE_EN
            last_x      <= 10'(X_INIT);
            drawn_valid <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    writeEn <= 1'b0;
                    if (draw) begin
                        sx      <= d_x;
                        col     <= '0;
                        row     <= '0;
                        busy    <= 1'b1;
                        writeEn <= 1'b1;
                        y       <= 10'(Y_POS);
`ifdef PLAT_ERASE_EN
                        if (drawn_valid && (last_x != d_x)) begin
                            state  <= ERASE;
                            x      <= last_x;
                            colour <= 3'b000;
                        end else begin
                            state  <= DRAW;
                            x      <= d_x;
                            colour <= COLOUR;
                        end
`else
                        state  <= DRAW;
                        x      <= d_x;
                        colour <= COLOUR;
`endif
                    end
                end
`ifdef PLAT_ERASE_EN
                ERASE: begin
                    if (last_pixel) begin
                        state  <= DRAW;
                        col    <= '0;
                        row    <= '0;
                        x      <= sx;
                        y      <= 10'(Y_POS);
                        colour <= COLOUR;
                    end else begin
                        col <= col_wrap ? '0 : col + COL_W'(1);
                        row <= col_wrap ? row + ROW_W'(1) : row;
                        x   <= col_wrap ? scan_base : x + 10'd1;
                        y   <= col_wrap ? y + 10'd1 : y;
                    end
                end
`endif
                DRAW: begin
                    if (last_pixel) begin
                        state   <= DONE;
                        writeEn <= 1'b0;
                        done    <= 1'b1;
                        x       <= sx;
                        y       <= 10'(Y_POS);
                        colour  <= COLOUR;
`ifdef PLAT_ERASE_EN
                        last_x      <= sx;
                        drawn_valid <= 1'b1;
`endif
                    end else begin
                        col <= col_wrap ? '0 : col + COL_W'(1);
                        row <= col_wrap ? row + ROW_W'(1) : row;
                        x   <= col_wrap ? scan_base : x + 10'd1;
                        y   <= col_wrap ? y + 10'd1 : y;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    writeEn <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_platform_gen2.sv
// Self-checking bench for platform_gen2: directed scenarios plus random movement,
// compared against a pixel-list and position model built from the paddle rules.
module tb_platform_gen2;

    localparam int         WIDTH  = 32;
    localparam int         HEIGHT = 2;
    localparam int         SPEED  = 2;
    localparam int         X_MAX  = 159;
    localparam int         X_INIT = 64;
    localparam int         Y_POS  = 110;
    localparam logic [2:0] COLOUR = 3'b100;
    localparam int         LIM    = X_MAX - WIDTH + 1;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       left = 1'b0, right = 1'b0, enable = 1'b0, draw = 1'b0;
    logic [9:0] x, y, d_x;
    logic [2:0] colour;
    logic       writeEn, busy, done;

    int vectors = 0;
    int miscompares = 0;
    int mdx = X_INIT;   // model paddle position
    int m_last = -1;    // model: left edge of the rectangle on screen, -1 when none

    platform_gen2 #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SPEED(SPEED), .X_MAX(X_MAX),
        .X_INIT(X_INIT), .Y_POS(Y_POS), .COLOUR(COLOUR)
    ) dut (
        .clk(clk), .resetn(resetn), .left(left), .right(right), .enable(enable),
        .draw(draw), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
        .busy(busy), .done(done), .d_x(d_x)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: the model moves the paddle from the inputs seen at the edge.
    task automatic tick();
        int t;
        @(posedge clk);
        if (resetn && enable && (left != right)) begin
            t = left ? mdx - SPEED : mdx + SPEED;
            if (t < 0)   t = 0;
            if (t > LIM) t = LIM;
            mdx = t;
        end
        #1;
    endtask

    task automatic render(input bit disturb);
        int snap;
        int ex_x[$], ex_y[$], ex_c[$];
        snap = mdx;
`ifdef PLAT_ERASE_EN
        if (m_last >= 0 && m_last != snap)
            for (int r = 0; r < HEIGHT; r++)
                for (int c = 0; c < WIDTH; c++) begin
                    ex_x.push_back(m_last + c); ex_y.push_back(Y_POS + r); ex_c.push_back(0);
                end
`endif
        for (int r = 0; r < HEIGHT; r++)
            for (int c = 0; c < WIDTH; c++) begin
                ex_x.push_back(snap + c); ex_y.push_back(Y_POS + r); ex_c.push_back(int'(COLOUR));
            end
        draw = 1'b1;
        tick();
        draw = 1'b0;
        for (int i = 0; i < ex_x.size(); i++) begin
            chk("write_en", 32'(writeEn), 32'd1);
            chk("pix_x", 32'(x), 32'(ex_x[i]));
            chk("pix_y", 32'(y), 32'(ex_y[i]));
            chk("pix_colour", 32'(colour), 32'(ex_c[i]));
            chk("busy_scan", 32'(busy), 32'd1);
            chk("done_scan", 32'(done), 32'd0);
            chk("d_x_scan", 32'(d_x), 32'(mdx));
            if (disturb && i == 10) begin
                draw = 1'b1; enable = 1'b1; left = 1'b1;
            end else begin
                draw = 1'b0; enable = 1'b0; left = 1'b0;
            end
            tick();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("write_en_done", 32'(writeEn), 32'd0);
        chk("busy_done", 32'(busy), 32'd1);
        tick();
        chk("done_clear", 32'(done), 32'd0);
        chk("busy_clear", 32'(busy), 32'd0);
        chk("write_en_idle", 32'(writeEn), 32'd0);
        chk("x_idle", 32'(x), 32'(snap));
        chk("y_idle", 32'(y), 32'(Y_POS));
        m_last = snap;
    endtask

    initial begin
        int snap;
        #1 resetn = 1'b0;
        #10;
        chk("rst_d_x", 32'(d_x), 32'(X_INIT));
        chk("rst_x", 32'(x), 32'(X_INIT));
        chk("rst_y", 32'(y), 32'(Y_POS));
        chk("rst_colour", 32'(colour), 32'(COLOUR));
        chk("rst_write_en", 32'(writeEn), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        resetn = 1'b1;
        tick();

        // First render from the reset position.
        render(1'b0);
        chk("d_x_after_first", 32'(d_x), 32'd64);

        // Three right ticks, then a render that erases the old rectangle when enabled.
        enable = 1'b1; right = 1'b1;
        repeat (3) tick();
        enable = 1'b0; right = 1'b0;
        chk("d_x_right3", 32'(d_x), 32'd70);
        render(1'b0);

        // Clamp at both edges.
        enable = 1'b1; right = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("d_x_right_clamp", 32'(d_x), 32'(mdx));
        end
        chk("d_x_max", 32'(d_x), 32'd128);
        right = 1'b0; left = 1'b1;
        for (int i = 0; i < 70; i++) begin
            tick();
            chk("d_x_left_clamp", 32'(d_x), 32'(mdx));
        end
        chk("d_x_min", 32'(d_x), 32'd0);

        // Conflicting requests and missing enable leave the position alone.
        enable = 1'b1; left = 1'b1; right = 1'b1;
        repeat (5) tick();
        enable = 1'b0; right = 1'b0;
        repeat (5) tick();
        left = 1'b0;
        enable = 1'b1; right = 1'b1;
        tick();
        enable = 1'b0; right = 1'b0;
        chk("d_x_hold_then_step", 32'(d_x), 32'(SPEED));

        // Random movement.
        for (int i = 0; i < 300; i++) begin
            enable = 1'($urandom_range(0, 1));
            left   = 1'($urandom_range(0, 1));
            right  = 1'($urandom_range(0, 1));
            tick();
            chk("d_x_random", 32'(d_x), 32'(mdx));
        end
        enable = 1'b0; left = 1'b0; right = 1'b0;
        if (mdx < SPEED) begin
            enable = 1'b1; right = 1'b1;
            repeat (4) tick();
            enable = 1'b0; right = 1'b0;
        end

        // Redraw request and left move mid-render: snapshot holds, position moves.
        snap = mdx;
        render(1'b1);
        chk("d_x_moved_mid_draw", 32'(d_x), 32'(snap - SPEED));

        // Asynchronous reset in the middle of a scan.
        snap = mdx;
        draw = 1'b1;
        tick();
        draw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("abort_pix_x", 32'(x), 32'(snap + i));
            tick();
        end
        chk("abort_write_en_pre", 32'(writeEn), 32'd1);
        resetn = 1'b0;
        #1;
        chk("abort_write_en", 32'(writeEn), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_d_x", 32'(d_x), 32'd64);
        mdx = X_INIT;
        m_last = -1;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        render(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
